// File: rtl/mem_access_unit.sv
// Memory access sequencer: word/halfword/byte loads with extension, sub-word stores as
// read-modify-write. Define MEM_ACCESS_MISALIGN_TRAP_EN to reject misaligned accesses.
module mem_access_unit #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              misalign
);

  typedef enum logic [1:0] {StIdle, StRdWait, StWrite, StDone} state_e;

  localparam logic [2:0] CntInit = 3'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic [1:0]        off_q, off_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_wr_q, mem_wr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              misalign_q, misalign_d;

  logic        is_word_req, is_half_req, misalign_req;
  logic [1:0]  off_req;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val, merged;

  // Reserved size 2'b11 behaves as a word access.
  always_comb begin
    is_half_req = (size == 2'b01);
    is_word_req = (size != 2'b01) && (size != 2'b10);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    misalign_req = (is_word_req && (addr[1:0] != 2'b00)) || (is_half_req && addr[0]);
`else
    misalign_req = 1'b0;
`endif
    // Without the trap, low address bits are forced to the natural alignment.
    if (is_word_req)      off_req = 2'b00;
    else if (is_half_req) off_req = {addr[1], 1'b0};
    else                  off_req = addr[1:0];
  end

  always_comb begin
    byte_sel = mem_rdata[8*off_q +: 8];
    half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (size_q)
      2'b01:   load_val = {{16{sign_q & half_sel[15]}}, half_sel};
      2'b10:   load_val = {{24{sign_q & byte_sel[7]}}, byte_sel};
      default: load_val = mem_rdata;
    endcase
    merged = mem_rdata;
    if (size_q == 2'b01) merged[16*off_q[1] +: 16] = wdata_q;
    else                 merged[8*off_q +: 8]      = wdata_q[7:0];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    size_d      = size_q;
    sign_d      = sign_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    mem_wr_d    = 1'b0;
    done_d      = 1'b0;
    misalign_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          wr_d    = wr;
          size_d  = size;
          sign_d  = sign_ext;
          off_d   = off_req;
          wdata_d = wdata[15:0];
          if (misalign_req) begin
            state_d    = StDone;
            done_d     = 1'b1;
            misalign_d = 1'b1;
          end else begin
            mem_addr_d = {addr[ADDR_W-1:2], 2'b00};
            if (wr && is_word_req) begin
              state_d     = StWrite;
              mem_wr_d    = 1'b1;
              mem_wdata_d = wdata;
            end else begin
              state_d = StRdWait;
              cnt_d   = CntInit;
            end
          end
        end
      end
      StRdWait: begin
        if (cnt_q == 3'd0) begin
          if (wr_q) begin
            state_d     = StWrite;
            mem_wr_d    = 1'b1;
            mem_wdata_d = merged;
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
            rdata_d = load_val;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StWrite: begin
        state_d = StDone;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      wr_q        <= 1'b0;
      size_q      <= 2'b00;
      sign_q      <= 1'b0;
      off_q       <= 2'b00;
      wdata_q     <= 16'h0;
      mem_addr_q  <= '0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      misalign_q  <= misalign_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign misalign  = misalign_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory access sequencer directly downstream of the address-select mux (regA / PC / ALUout / exception-vector address). It takes the selected byte address plus a request from the control unit, then drives the word-wide memory. Word, halfword and byte loads are extracted and extended here. Halfword and byte stores are done as read-modify-write; misaligned accesses are flagged. Gives the multicycle control FSM a single req/done handshake instead of hard-coded memory wait states.

Parameters:
MEM_LAT, 2, memory read latency in cycles from mem_addr stable to mem_rdata valid (legal 1..7)
ADDR_W, 32, address width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
req  input  1  start access; sampled only in IDLE
wr  input  1  1 = store, 0 = load
size  input  2  00 word, 01 halfword, 10 byte, 11 reserved (treated as word)
sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend
addr  input  ADDR_W  byte address from address-select mux
wdata  input  32  store data; sub-word data in low bits
mem_rdata  input  32  memory read data
mem_addr  output  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
mem_wr  output  1  memory write strobe, one cycle per write
mem_wdata  output  32  memory write data
rdata  output  32  load result, held until next completed load
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
misalign  output  1  one-cycle pulse with done on rejected access

Behaviour:
- All outputs registered. Reset value of every output is 0. Reset forces IDLE and mem_wr=0 immediately, mid-operation included; an interrupted access is abandoned.
- On the req edge in IDLE: addr, wr, size, sign_ext, wdata are latched. Inputs are ignored until the next IDLE. req while busy is dropped, not queued.
- States: IDLE, RD_WAIT, WRITE, DONE.
- IDLE + req, misaligned: go to DONE with misalign=1. Misaligned means word with addr[1:0]!=0, or halfword with addr[0]=1. No memory access is made and rdata is unchanged.
- IDLE + req, word store: go to WRITE.
- IDLE + req, any load or sub-word store: go to RD_WAIT with cnt=MEM_LAT-1.
- RD_WAIT: cnt decrements each edge. At the edge where cnt==0, mem_rdata is captured.
  - Load: extract, extend, write rdata, go to DONE.
  - Sub-word store: merge, go to WRITE.
- WRITE: mem_wr=1 for exactly one cycle with mem_wdata, then DONE.
- DONE: done=1 for one cycle, then IDLE. busy is still 1 in DONE.
- Latency, counted from the req edge to the edge that raises done:
  - word store: 2 edges
  - load: MEM_LAT+1 edges
  - sub-word store: MEM_LAT+2 edges
  - misaligned: 1 edge
- Little-endian byte lanes: offset 0 = bits 7:0, offset 3 = bits 31:24. Halfword offset 0 = bits 15:0, offset 2 = bits 31:16.
- Merge: only the addressed lane(s) are replaced by wdata[7:0] or wdata[15:0]; the other lanes keep the read value.
- Load extension: bit 7 (byte) or bit 15 (halfword) of the selected lane is replicated when sign_ext=1, else zeros.
- mem_addr is held stable from entry to RD_WAIT/WRITE until the following IDLE.
- Back-to-back: req high in the cycle after done is accepted; minimum 1 idle cycle between accesses.

Optional Feature:
MEM_ACCESS_MISALIGN_TRAP_EN. Defined: misalignment detection as above. Undefined: no misalignment check. The low address bits are forced to alignment (word: addr[1:0]=0; halfword: addr[0]=0) and the access proceeds normally. misalign is tied to 0.

Test Plan:
- MEM_LAT=2, memory word 0x100 = 0x8899AABB, load word addr=0x100 -> done at 3rd edge after req, rdata=0x8899AABB, mem_wr never 1.
- Load byte addr=0x103, sign_ext=1 -> rdata=0xFFFFFF88. Same with sign_ext=0 -> 0x00000088. Halfword 0x102, sign_ext=1 -> 0xFFFF8899.
- Store byte wdata=0x12 to 0x101 over 0x8899AABB -> single mem_wr pulse with mem_wdata=0x889912BB, done at 4th edge.
- Store word addr=0x0FE (trap enabled) -> misalign=1 and done=1 on 1st edge, no mem_wr. Trap disabled -> mem_addr=0x0FC, mem_wr=1.
- Assert reset low while in RD_WAIT -> busy, done, mem_wr drop to 0 without waiting for a clock edge. req after release completes normally.
- req held high through a 3-cycle load -> exactly one access and one done pulse. A second access starts only after IDLE is re-entered.
